// File: rtl/spi_gyro_if.sv
// spi_gyro_if
//   Bundles every signal exchanged between the gyro responder and its
//   surroundings: the SPI pins, the synthetic sample feed, the interrupt and
//   the exported control registers.
//
//   Handshake: sample_valid is a one-cycle strobe with no ready. The responder
//   always accepts; the sample_x/y/z values are taken in the cycle where
//   sample_valid is high and may change freely afterwards.
//
//   Modports:
//     slave  - the responder (SPI slave, sample consumer)
//     master - the SPI master / sample source (bench or fusion path)
interface spi_gyro_if;
  logic        sclk;
  logic        mosi;
  logic        ss_n;
  logic        miso;
  logic        sample_valid;
  logic [15:0] sample_x;
  logic [15:0] sample_y;
  logic [15:0] sample_z;
  logic        int2;
  logic [7:0]  ctrl1;
  logic [7:0]  ctrl2;
  logic [7:0]  ctrl3;
  logic [7:0]  ctrl4;
  logic [7:0]  ctrl5;

  modport slave (
    input  sclk, mosi, ss_n, sample_valid, sample_x, sample_y, sample_z,
    output miso, int2, ctrl1, ctrl2, ctrl3, ctrl4, ctrl5
  );

  modport master (
    output sclk, mosi, ss_n, sample_valid, sample_x, sample_y, sample_z,
    input  miso, int2, ctrl1, ctrl2, ctrl3, ctrl4, ctrl5
  );
endinterface

// File: rtl/spi_gyro_responder.sv
// spi_gyro_responder
//   SPI mode-3 slave emulating a 3-axis gyro register file, clocked entirely
//   in the clk domain (clk must be >= 8x sclk). Supports single/burst
//   register writes and reads with optional auto-increment, a coherent
//   sample snapshot and a data-ready interrupt.
//
//   Ports:
//     clk, rst   - system clock, synchronous active-high reset
//     bus        - spi_gyro_if.slave (SPI pins, sample feed, int2, ctrl1..5)
//     dbg_state  - current FSM state (0 IDLE, 1 CMD, 2 WRITE, 3 READ)
module spi_gyro_responder #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter int         SYNC_STAGES  = 2      // must be >= 2
) (
  input  logic        clk,
  input  logic        rst,
  spi_gyro_if.slave   bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WRITE = 2'd2, READ = 2'd3} state_t;

  // ---------------- input synchronizers and edge detect ----------------
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic sclk_d, ss_d;

  // ss_n synchronizer resets low (as if mid-frame): a real ss_n that is low
  // across reset then produces no fall, so the rest of that frame is ignored
  // until ss_n has been seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '1;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_d    <= 1'b1;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss_n};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d & ~ss_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~ss_s;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;

  // ---------------- register file state ----------------
  state_t      state;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sh;
  logic [7:0]  tx;
  logic [5:0]  addr;
  logic        ms;
  logic        miso_r, int2_r;
  logic [7:0]  ctrl_r [5];
  logic [15:0] out_x, out_y, out_z;
  logic [15:0] sh_x, sh_y, sh_z;
  logic        pending, drdy, overrun;

  logic [7:0] rx_byte;
  logic       byte_done;
  logic [5:0] next_addr;
  logic       drdy_clr;
  logic       load_direct, load_shadow;

  assign rx_byte   = {rx_sh, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE);
  assign next_addr = ms ? addr + 6'd1 : addr;   // 0x3F wraps to 0x00
  // The last byte of the burst (0x2D) completes on its 8th rise; that is
  // also where the tx reload happens, so one condition covers both the
  // reload case and a frame that ends right after that byte.
  assign drdy_clr    = (state == READ) && byte_done && (addr == 6'h2D);
  assign load_direct = bus.sample_valid & ss_s;
  assign load_shadow = pending & ss_rise;

  function automatic logic [7:0] reg_at(input logic [5:0] a);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      6'h0F:                             v = WHO_AM_I_VAL;
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24: v = ctrl_r[a[2:0]];
      6'h27:                             v = {overrun, 3'b000, drdy, 3'b000};
      6'h28:                             v = out_x[7:0];
      6'h29:                             v = out_x[15:8];
      6'h2A:                             v = out_y[7:0];
      6'h2B:                             v = out_y[15:8];
      6'h2C:                             v = out_z[7:0];
      6'h2D:                             v = out_z[15:8];
      default:                           v = 8'h00;
    endcase
    return v;
  endfunction

  // ---------------- SPI FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      rx_sh   <= 7'd0;
      tx      <= 8'd0;
      addr    <= 6'd0;
      ms      <= 1'b0;
      miso_r  <= 1'b1;
      int2_r  <= 1'b0;
      for (int i = 0; i < 5; i++) ctrl_r[i] <= 8'h00;
    end else begin
      int2_r <= drdy & ctrl_r[2][3];
      if (state == IDLE) begin
        miso_r  <= 1'b1;
        bit_cnt <= 3'd0;
        if (ss_fall) begin
          state  <= CMD;
          tx     <= 8'h00;
          miso_r <= 1'b0;
        end
      end else if (ss_rise) begin
        // Frame ended: any partial byte is dropped with no side effect.
        state   <= IDLE;
        miso_r  <= 1'b1;
        bit_cnt <= 3'd0;
      end else begin
        if (sclk_rise) begin
          rx_sh   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (sclk_fall) begin
          miso_r <= tx[7];
          tx     <= {tx[6:0], 1'b0};
        end
        if (byte_done) begin
          case (state)
            CMD: begin
              ms   <= rx_byte[6];
              addr <= rx_byte[5:0];
              if (rx_byte[7]) begin
                state <= READ;
                tx    <= reg_at(rx_byte[5:0]);
              end else begin
                state <= WRITE;
              end
            end
            WRITE: begin
              if (addr >= 6'h20 && addr <= 6'h24) ctrl_r[addr[2:0]] <= rx_byte;
              addr <= next_addr;
            end
            READ: begin
              tx   <= reg_at(next_addr);
              addr <= next_addr;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- sample capture, drdy / overrun ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_x   <= 16'd0;
      out_y   <= 16'd0;
      out_z   <= 16'd0;
      sh_x    <= 16'd0;
      sh_y    <= 16'd0;
      sh_z    <= 16'd0;
      pending <= 1'b0;
      drdy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // Inside a frame new samples wait in the shadow so a burst read never
      // mixes two samples; the newest strobe overwrites the shadow.
      if (bus.sample_valid && !ss_s) begin
        sh_x    <= bus.sample_x;
        sh_y    <= bus.sample_y;
        sh_z    <= bus.sample_z;
        pending <= 1'b1;
      end else if (ss_rise) begin
        pending <= 1'b0;
      end

      if (load_direct) begin
        out_x <= bus.sample_x;
        out_y <= bus.sample_y;
        out_z <= bus.sample_z;
      end else if (load_shadow) begin
        out_x <= sh_x;
        out_y <= sh_y;
        out_z <= sh_z;
      end

      if (load_direct || load_shadow) begin
        drdy <= 1'b1;
        if (drdy) overrun <= 1'b1;
      end else if (drdy_clr) begin
        drdy    <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign bus.miso  = miso_r;
  assign bus.int2  = int2_r;
  assign bus.ctrl1 = ctrl_r[0];
  assign bus.ctrl2 = ctrl_r[1];
  assign bus.ctrl3 = ctrl_r[2];
  assign bus.ctrl4 = ctrl_r[3];
  assign bus.ctrl5 = ctrl_r[4];
  assign dbg_state = state;

endmodule

// File: tb/tb_spi_gyro_responder.sv
module tb_spi_gyro_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_gyro_if bus();
  logic [1:0] dbg_state;

  spi_gyro_responder #(.WHO_AM_I_VAL(8'hD3), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  bit quiet    = 1'b0;   // DUT settled with ss_n high: idle outputs are meaningful
  bit in_frame = 1'b0;

  // ---------------- register-map model ----------------
  logic [7:0]  m_ctrl [5];
  logic [15:0] m_out  [3];
  logic [15:0] m_sh   [3];
  bit          m_pend, m_drdy, m_ovr;
  logic [5:0]  cur_addr;
  bit          cur_ms;

  logic [7:0] exp_q [$];
  logic [7:0] rx_log [$];

  function automatic logic [7:0] m_reg(input logic [5:0] a);
    int idx;
    logic [15:0] w;
    if (a == 6'h0F) return 8'hD3;
    if (a >= 6'h20 && a <= 6'h24) return m_ctrl[int'(a) - 32];
    if (a == 6'h27) return {m_ovr, 3'b000, m_drdy, 3'b000};
    if (a >= 6'h28 && a <= 6'h2D) begin
      idx = int'(a) - 40;
      w = m_out[idx / 2];
      return (idx % 2 == 1) ? w[15:8] : w[7:0];
    end
    return 8'h00;
  endfunction

  function automatic void m_publish(input logic [15:0] x, y, z);
    if (m_drdy) m_ovr = 1'b1;
    m_drdy = 1'b1;
    m_out[0] = x; m_out[1] = y; m_out[2] = z;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (quiet) begin
      check8("ctrl1", bus.ctrl1, m_ctrl[0]);
      check8("ctrl2", bus.ctrl2, m_ctrl[1]);
      check8("ctrl3", bus.ctrl3, m_ctrl[2]);
      check8("ctrl4", bus.ctrl4, m_ctrl[3]);
      check8("ctrl5", bus.ctrl5, m_ctrl[4]);
      check8("int2", {7'd0, bus.int2}, {7'd0, m_drdy & m_ctrl[2][3]});
      check8("miso_idle", {7'd0, bus.miso}, 8'h01);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic spi_begin();
    quiet = 1'b0;
    in_frame = 1'b1;
    bus.ss_n = 1'b0;
    #160;
  endtask

  task automatic spi_end();
    #160;
    bus.ss_n = 1'b1;
    in_frame = 1'b0;
    if (m_pend) begin
      m_publish(m_sh[0], m_sh[1], m_sh[2]);
      m_pend = 1'b0;
    end
    #200;
    quiet = 1'b1;
  endtask

  // Master shifts mosi on sclk fall and samples miso just before the rise.
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int b = 7; b >= 0; b--) begin
      bus.sclk = 1'b0;
      bus.mosi = tx[b];
      #80;
      rx[b] = bus.miso;
      bus.sclk = 1'b1;
      #80;
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n);
    for (int b = 7; b > 7 - n; b--) begin
      bus.sclk = 1'b0;
      bus.mosi = tx[b];
      #80;
      bus.sclk = 1'b1;
      #80;
    end
  endtask

  task automatic rd_cmd(input logic [7:0] cmd);
    logic [7:0] rx;
    rx_log.delete();
    spi_begin();
    spi_byte(cmd, rx);
    cur_addr = cmd[5:0];
    cur_ms   = cmd[6];
  endtask

  task automatic rd_data(input int n);
    logic [7:0] rx;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_reg(cur_addr));
      spi_byte(8'h00, rx);
      rx_log.push_back(rx);
      check8("rd_byte", rx, exp_q.pop_front());
      if (cur_addr == 6'h2D) begin
        m_drdy = 1'b0;
        m_ovr  = 1'b0;
      end
      if (cur_ms) cur_addr = cur_addr + 6'd1;
    end
  endtask

  task automatic wr_frame(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] rx;
    spi_begin();
    spi_byte({2'b00, a}, rx);
    spi_byte(d, rx);
    if (a >= 6'h20 && a <= 6'h24) m_ctrl[int'(a) - 32] = d;
    spi_end();
  endtask

  task automatic strobe(input logic [15:0] x, y, z);
    if (!in_frame) quiet = 1'b0;
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_x = x; bus.sample_y = y; bus.sample_z = z;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    if (in_frame) begin
      m_sh[0] = x; m_sh[1] = y; m_sh[2] = z;
      m_pend = 1'b1;
    end else begin
      m_publish(x, y, z);
      repeat (4) @(negedge clk);
      quiet = 1'b1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [7:0] exp_burst [6];
    exp_burst = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
    for (int i = 0; i < 5; i++) m_ctrl[i] = 8'h00;
    for (int i = 0; i < 3; i++) begin m_out[i] = 16'h0; m_sh[i] = 16'h0; end
    m_pend = 1'b0; m_drdy = 1'b0; m_ovr = 1'b0;

    rst = 1'b1;
    bus.sclk = 1'b1; bus.mosi = 1'b0; bus.ss_n = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_x = 16'h0; bus.sample_y = 16'h0; bus.sample_z = 16'h0;
    repeat (5) @(negedge clk);
    check8("rst_miso", {7'd0, bus.miso}, 8'h01);
    check8("rst_int2", {7'd0, bus.int2}, 8'h00);
    check8("rst_ctrl1", bus.ctrl1, 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    quiet = 1'b1;

    // WHO_AM_I
    rd_cmd(8'h8F); rd_data(1); spi_end();
    check8("who_am_i", rx_log[0], 8'hD3);

    // Init writes
    wr_frame(6'h20, 8'h0F);
    wr_frame(6'h22, 8'h08);
    wr_frame(6'h23, 8'h30);
    wr_frame(6'h24, 8'h02);
    wr_frame(6'h0F, 8'h55);   // read-only, ignored
    check8("init_ctrl1", bus.ctrl1, 8'h0F);
    check8("init_ctrl2", bus.ctrl2, 8'h00);
    check8("init_ctrl3", bus.ctrl3, 8'h08);
    check8("init_ctrl4", bus.ctrl4, 8'h30);
    check8("init_ctrl5", bus.ctrl5, 8'h02);

    // Burst read of a fresh sample
    strobe(16'h1234, 16'hABCD, 16'h8001);
    check8("int2_set", {7'd0, bus.int2}, 8'h01);
    rd_cmd(8'hE8); rd_data(6); spi_end();
    for (int i = 0; i < 6; i++) check8("burst_lit", rx_log[i], exp_burst[i]);
    check8("int2_clr", {7'd0, bus.int2}, 8'h00);

    // No auto-increment, then wrap 0x3F -> 0x00
    rd_cmd(8'hA8); rd_data(3); spi_end();
    for (int i = 0; i < 3; i++) check8("noinc_lit", rx_log[i], 8'h34);
    rd_cmd(8'hFF); rd_data(2); spi_end();
    check8("wrap_3f", rx_log[0], 8'h00);
    check8("wrap_00", rx_log[1], 8'h00);

    // Abort a write after 4 data bits
    begin
      logic [7:0] rx;
      spi_begin();
      spi_byte(8'h20, rx);
      spi_bits(8'hFF, 4);
      spi_end();
    end
    check8("abort_ctrl1", bus.ctrl1, 8'h0F);
    rd_cmd(8'hA0); rd_data(1); spi_end();
    check8("after_abort", rx_log[0], 8'h0F);

    // Coherence: a strobe during a burst does not disturb it
    rd_cmd(8'hE8); rd_data(3);
    strobe(16'h5555, 16'h6666, 16'h7777);
    rd_data(3); spi_end();
    for (int i = 0; i < 6; i++) check8("coh_old", rx_log[i], exp_burst[i]);
    rd_cmd(8'hE8); rd_data(6); spi_end();
    check8("coh_new_xl", rx_log[0], 8'h55);
    check8("coh_new_zh", rx_log[5], 8'h77);

    // Two strobes without a read: drdy and overrun
    strobe(16'h0102, 16'h0304, 16'h0506);
    strobe(16'h0708, 16'h090A, 16'h0B0C);
    rd_cmd(8'hA7); rd_data(1); spi_end();
    check8("status_ovr", rx_log[0], 8'h88);

    quiet = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
